// File: rtl/frv_gprs_wb_ctrl_if.sv
// frv_gprs_wb_ctrl_if: pipeline, long-latency unit and register-file write-port bundle for frv_gprs_wb_ctrl
interface frv_gprs_wb_ctrl_if;
    logic        p_wen, p_wide, p_hi_rev, p_stall;
    logic [4:0]  p_addr;
    logic [31:0] p_wdata, p_wdata_hi;
    logic        lu_rsv_valid, lu_rsv_wide, lu_rsv_ready;
    logic [4:0]  lu_rsv_addr;
    logic        lu_valid, lu_wide, lu_hi_rev, lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_wdata, lu_wdata_hi;
    logic [4:0]  hz_addr1, hz_addr2, hz_addr3;
    logic        hz_busy;
    logic        rd_wen, rd_wide, rd_wdata_hi_rev;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, rd_wdata_hi;
    logic [31:0] busy;
    logic        err;
    modport master (
        output p_wen, p_wide, p_addr, p_wdata, p_wdata_hi, p_hi_rev,
        output lu_rsv_valid, lu_rsv_wide, lu_rsv_addr,
        output lu_valid, lu_wide, lu_addr, lu_wdata, lu_wdata_hi, lu_hi_rev,
        output hz_addr1, hz_addr2, hz_addr3,
        input  p_stall, lu_rsv_ready, lu_ready, hz_busy,
        input  rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi, rd_wdata_hi_rev, busy, err
    );
    modport slave (
        input  p_wen, p_wide, p_addr, p_wdata, p_wdata_hi, p_hi_rev,
        input  lu_rsv_valid, lu_rsv_wide, lu_rsv_addr,
        input  lu_valid, lu_wide, lu_addr, lu_wdata, lu_wdata_hi, lu_hi_rev,
        input  hz_addr1, hz_addr2, hz_addr3,
        output p_stall, lu_rsv_ready, lu_ready, hz_busy,
        output rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi, rd_wdata_hi_rev, busy, err
    );
endinterface

// File: rtl/frv_gprs_wb_ctrl.sv
// frv_gprs_wb_ctrl: shares the GPR write port between pipeline writeback and a long-latency unit,
// tracking LU destinations in a busy scoreboard and reporting hazards.
module frv_gprs_wb_ctrl #(
    parameter int LU_DEPTH   = 2,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 4
) (
    input logic               g_clk,
    input logic               g_resetn,
    frv_gprs_wb_ctrl_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1) + 1;

    logic [70:0]   r_fifo [4];
    logic [1:0]    r_rd_ptr, r_wr_ptr;
    logic [2:0]    r_fcnt;
    logic [3:0]    r_cnt;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_busy;
    logic          r_err;

    logic [70:0] w_head;
    logic [31:0] w_rsv_mask, w_p_mask, w_lu_mask, w_hd_mask;
    logic        w_rsv_bad, w_rsv_ok, w_push, w_fne, w_waw, w_starved, w_p_win, w_lu_win;

    function automatic logic [31:0] reg_mask(input logic [4:0] a, input logic w);
        return (32'd1 << a) | (w ? 32'd1 << {a[4:1], 1'b1} : 32'd0);
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(LU_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // head entry layout: {hi_rev, wide, addr[4:0], wdata_hi, wdata}
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_rsv_mask = reg_mask(bus.lu_rsv_addr, bus.lu_rsv_wide) & ~32'd1;
    assign w_p_mask   = reg_mask(bus.p_addr, bus.p_wide);
    assign w_lu_mask  = reg_mask(bus.lu_addr, bus.lu_wide) & ~32'd1;
    assign w_hd_mask  = reg_mask(w_head[68:64], w_head[69]);

    assign w_rsv_bad  = bus.lu_rsv_valid & bus.lu_rsv_wide & bus.lu_rsv_addr[0];
    assign bus.lu_rsv_ready = !(bus.lu_rsv_wide & bus.lu_rsv_addr[0]) && !(|(w_rsv_mask & r_busy))
                              && (r_cnt < 4'(MAX_OUT));
    assign w_rsv_ok   = bus.lu_rsv_valid & bus.lu_rsv_ready;
    assign bus.lu_ready = r_fcnt != 3'(LU_DEPTH);
    assign w_push     = bus.lu_valid & bus.lu_ready;
    assign w_fne      = r_fcnt != 3'd0;

    // a WAW-blocked or starved pipeline yields the port to the LU head
    assign w_waw      = bus.p_wen & |(w_p_mask & r_busy);
    assign w_starved  = w_fne && (r_starve >= SW'(STARVE_MAX));
    assign w_p_win    = bus.p_wen & !w_waw & !w_starved;
    assign w_lu_win   = w_fne & !w_p_win;

    assign bus.p_stall         = g_resetn & bus.p_wen & !w_p_win;
    assign bus.rd_wen          = g_resetn & (w_p_win | w_lu_win);
    assign bus.rd_wide         = w_lu_win ? w_head[69]    : bus.p_wide;
    assign bus.rd_addr         = w_lu_win ? w_head[68:64] : bus.p_addr;
    assign bus.rd_wdata_hi     = w_lu_win ? w_head[63:32] : bus.p_wdata_hi;
    assign bus.rd_wdata        = w_lu_win ? w_head[31:0]  : bus.p_wdata;
    assign bus.rd_wdata_hi_rev = w_lu_win ? w_head[70]    : bus.p_hi_rev;

    assign bus.hz_busy = r_busy[bus.hz_addr1] | r_busy[bus.hz_addr2] | r_busy[bus.hz_addr3];
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;

    always_ff @(posedge g_clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= {bus.lu_hi_rev, bus.lu_wide, bus.lu_addr, bus.lu_wdata_hi, bus.lu_wdata};
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_fcnt   <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
            r_busy   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wr_ptr <= w_push ? nxt(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr <= w_lu_win ? nxt(r_rd_ptr) : r_rd_ptr;
            r_fcnt   <= r_fcnt + 3'(w_push) - 3'(w_lu_win);
            r_cnt    <= r_cnt + 4'(w_rsv_ok) - 4'(w_lu_win);
            r_busy   <= (r_busy & ~(w_lu_win ? w_hd_mask : 32'd0)) | (w_rsv_ok ? w_rsv_mask : 32'd0);
            r_starve <= w_lu_win ? '0 : (w_p_win & w_fne) ? r_starve + 1'b1 : r_starve;
            r_err    <= r_err | w_rsv_bad | (w_push & |(w_lu_mask & ~r_busy));
        end
    end
endmodule

// File: doc/frv_gprs_wb_ctrl.md
# frv_gprs_wb_ctrl

Write-port controller for the general purpose register file. It shares the file's single write port between the in-order pipeline writeback and a long-latency unit (LU), such as a masked multi-cycle coprocessor, whose results return out of step with the pipeline. It keeps a per-register busy scoreboard for LU destinations and reports read/write hazards so the pipeline can stall. It sits directly in front of the register file's `rd_*` write inputs.

## Interface
Parameters:
- `LU_DEPTH`, 2: LU result buffer depth (1..4).
- `MAX_OUT`, 4: maximum outstanding LU reservations (1..8).
- `STARVE_MAX`, 4: consecutive cycles an LU result may lose arbitration before it is forced through.

Ports:
- `g_clk` in 1: clock.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `p_wen, p_wide` in 1 each: pipeline write request and wide flag.
- `p_addr` in 5, `p_wdata` in 32, `p_wdata_hi` in 32, `p_hi_rev` in 1: pipeline write fields.
- `p_stall` out 1: pipeline write not taken this cycle; hold all `p_*` fields.
- `lu_rsv_valid` in 1, `lu_rsv_wide` in 1, `lu_rsv_addr` in 5: LU reserves a destination at issue.
- `lu_rsv_ready` out 1: reservation accepted.
- `lu_valid` in 1, `lu_wide` in 1, `lu_addr` in 5, `lu_wdata` in 32, `lu_wdata_hi` in 32, `lu_hi_rev` in 1: LU result.
- `lu_ready` out 1: result buffer not full.
- `hz_addr1, hz_addr2, hz_addr3` in 5 each: decode-stage source addresses.
- `hz_busy` out 1: any source address is busy.
- `rd_wen, rd_wide` out 1 each, `rd_addr` out 5, `rd_wdata, rd_wdata_hi` out 32 each, `rd_wdata_hi_rev` out 1: register file write port.
- `busy` out 32: scoreboard.
- `err` out 1: sticky protocol error.

## Operation
Reservation:
- A wide reservation covers registers `addr` and `addr|1`; it requires `addr[0]=0`, otherwise `err` is set and the request is rejected.
- `lu_rsv_ready` = all covered registers not busy AND outstanding count < `MAX_OUT`. The check uses current-cycle state.
- On `lu_rsv_valid && lu_rsv_ready`: set the covered busy bits and increment the outstanding count. Bit 0 is never set.

Result buffer:
- FIFO of `LU_DEPTH` entries; accepted on `lu_valid && lu_ready`.
- A result arriving with any covered register not busy sets `err`. It is still buffered and written.

Arbitration (combinational, each cycle):
- A pipeline write to a busy register (either half if wide) is a WAW hazard: `p_stall=1` and the LU head is eligible.
- Otherwise, if `p_wen` and `starve_cnt < STARVE_MAX`: the pipeline wins. If the FIFO is non-empty, `starve_cnt` increments.
- Otherwise, if the FIFO is non-empty: the LU head wins, `p_stall = p_wen`, and `starve_cnt` clears.
- `rd_*` carry the winner's fields; `rd_wen=0` when there is no winner.

LU commit:
- Pop the FIFO, clear the covered busy bits, decrement the outstanding count.
- A commit and a reservation in the same cycle both update the count (net 0).
- Writes to x0 pass through; the register file discards them.

Hazard and error outputs:
- `hz_busy` = OR of `busy[hz_addrN]`. Address 0 never matches.
- `err` clears only on reset.

## Timing
- Reset (async): FIFO empty, `busy=0`, count=0, `starve_cnt=0`, `err=0`. While `g_resetn` is low, `rd_wen=0` and `p_stall=0` regardless of inputs.
- Reservation accepted in cycle t: `busy` and `hz_busy` are visible in t+1.
- Result accepted in t: earliest `rd_wen` in t+1; there is no write-through.
- Commit in cycle c: the register file holds the data at edge c. The busy bit is low and `hz_busy` drops in c+1, the same cycle the new value is readable.
- Reserving a register that is being committed in the same cycle is rejected that cycle and accepted in the next.
- Full FIFO: `lu_ready=0`. A commit in the same cycle does not raise `lu_ready` (no bypass).
- Worst-case LU wait under continuous pipeline writes: `STARVE_MAX` cycles, then one forced commit.
- Reset mid-operation discards buffered results and reservations. The LU is reset on the same signal.

## Test plan
- Reserve x5 in cycle 0, result 0xDEADBEEF accepted in cycle 3, no pipeline traffic: `rd_wen=1`, `rd_addr=5` in cycle 4; `busy[5]` 1 during cycles 1..4, 0 in cycle 5.
- Wide reserve x6 then a result with `lu_hi_rev=1`: one `rd_wide=1` write with `rd_wdata_hi_rev=1`; bits 6 and 7 clear together. A wide reserve of x7 sets `err`.
- Pipeline `p_wen` every cycle with one LU result pending, `STARVE_MAX=4`: pipeline wins 4 cycles, then LU commits with `p_stall=1` for exactly one cycle.
- Pipeline write to busy x9: `p_stall` held until the LU x9 commit, then the pipeline write takes the port the next cycle.
- `MAX_OUT=4`: four reservations accepted, fifth `lu_rsv_ready=0`; after one commit the fifth is accepted. Two results with FIFO depth 2 and port blocked: `lu_ready=0`.
- Assert `g_resetn` low with 2 buffered results: `busy=0`, `lu_ready=1`, no `rd_wen` after reset release.
